// File: rtl/mux4_1_rr_pkg.sv
// rtl/mux4_1_rr_pkg.sv - shared widths, lane count and lane select codes for the 4:1 merge and its demux
package mux4_1_rr_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int NUM_CH         = 4;

  // Lane select codes; a downstream 1:4 demux decodes out_select with these.
  typedef enum logic [1:0] {
    SEL_LANE1 = 2'b00,
    SEL_LANE2 = 2'b01,
    SEL_LANE3 = 2'b10,
    SEL_LANE4 = 2'b11
  } lane_sel_e;

endpackage

// File: rtl/mux4_1_rr_rr_arbiter4.sv
// rtl/mux4_1_rr_rr_arbiter4.sv - combinational 4-way round-robin arbiter
module rr_arbiter4
  import mux4_1_rr_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic              gnt_valid,
  output logic [1:0]        gnt
);

  logic [1:0] idx;

  // Scan lanes starting just after the last winner; the first requester found wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = last;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last + 2'(k);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_1_rr.sv
// rtl/mux4_1_rr.sv - four buffered lanes merged round-robin into one registered output
module mux4_1_rr
  import mux4_1_rr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [DATA_W-1:0] in_data_4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_select
);

  logic [DATA_W-1:0] lane_in  [NUM_CH];
  logic [DATA_W-1:0] lane_buf [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [1:0]        last_grant;
  logic              gnt_valid;
  logic [1:0]        gnt;
  logic              load;

  assign lane_in[0] = in_data_1;
  assign lane_in[1] = in_data_2;
  assign lane_in[2] = in_data_3;
  assign lane_in[3] = in_data_4;

  // A lane accepts only while its single-entry buffer is empty, so a lane is
  // never granted and refilled at the same edge.
  assign in_ready = ~full;

  rr_arbiter4 u_arb (
    .req       (full),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // The output register may take a new beat when empty or being drained this cycle.
  assign load = (!out_valid || out_ready) && gnt_valid;

  // Lane buffers, output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_select <= SEL_LANE1;
      last_grant <= SEL_LANE4;
      for (int i = 0; i < NUM_CH; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && !full[i]) begin
          full[i]     <= 1'b1;
          lane_buf[i] <= lane_in[i];
        end
      end
      if (load) begin
        out_data   <= lane_buf[gnt];
        out_select <= gnt;
        out_valid  <= 1'b1;
        full[gnt]  <= 1'b0;
        last_grant <= gnt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_1_rr.sv
// tb/tb_mux4_1_rr.sv - self-checking bench for the round-robin 4:1 merge
module tb_mux4_1_rr;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] lane_in [4];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_select;

  int checks   = 0;
  int failures = 0;

  // Reference: per-lane queues of accepted, not-yet-output beats plus the output register.
  logic [W-1:0] lane_q [4][$];
  logic         ov_m;
  logic [W-1:0] od_m;
  logic [1:0]   os_m;
  logic [1:0]   last_m;

  always #5 clk = ~clk;

  mux4_1_rr #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data_1  (lane_in[0]),
    .in_data_2  (lane_in[1]),
    .in_data_3  (lane_in[2]),
    .in_data_4  (lane_in[3]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_select (out_select)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) lane_q[i].delete();
    ov_m   = 1'b0;
    od_m   = '0;
    os_m   = 2'b00;
    last_m = 2'b11;
  endtask

  // Advance one clock: predict from the rules, then land on the next falling edge.
  task automatic cycle();
    logic [3:0]   acc;
    logic [W-1:0] cap [4];
    int g;
    int j;
    acc = '0;
    g   = -1;
    for (int i = 0; i < 4; i++) begin
      cap[i] = lane_in[i];
      if (in_valid[i] && lane_q[i].size() == 0) acc[i] = 1'b1;
    end
    if (!ov_m || out_ready) begin
      for (int k = 1; k <= 4; k++) begin
        j = (int'(last_m) + k) % 4;
        if (g < 0 && lane_q[j].size() != 0) g = j;
      end
    end
    @(posedge clk);
    if (g >= 0) begin
      od_m   = lane_q[g].pop_front();
      os_m   = 2'(g);
      ov_m   = 1'b1;
      last_m = 2'(g);
    end else if (ov_m && out_ready) begin
      ov_m = 1'b0;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) lane_q[i].push_back(cap[i]);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) lane_in[i] = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 4'b1111) begin failures++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
    checks++;
    if (out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (out_select !== 2'b00) begin failures++; $display("FAIL reset_out_select got=%b exp=00", out_select); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    apply_reset();
    in_valid   = 4'b0010;
    lane_in[1] = 4'hA;
    out_ready  = 1'b1;
    cycle();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", out_valid); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || out_select !== 2'b01) begin
      failures++;
      $display("FAIL single_beat got v=%b d=%h s=%b exp v=1 d=a s=01", out_valid, out_data, out_select);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hA || out_select !== 2'b01) begin
      failures++;
      $display("FAIL single_drain got v=%b d=%h s=%b exp v=0 d=a s=01", out_valid, out_data, out_select);
    end
  endtask

  task automatic test_all_four();
    apply_reset();
    for (int i = 0; i < 4; i++) lane_in[i] = 4'(i + 1);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    cycle();
    in_valid = '0;
    checks++;
    if (in_ready !== 4'b0000) begin failures++; $display("FAIL all4_full got=%b exp=0000", in_ready); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'(k + 1) || out_select !== 2'(k)) begin
        failures++;
        $display("FAIL all4_order k=%0d got v=%b d=%h s=%b exp v=1 d=%0d s=%0d",
                 k, out_valid, out_data, out_select, k + 1, k);
      end
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL all4_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_alternate();
    apply_reset();
    in_valid  = 4'b0101;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      lane_in[0] = 4'($urandom_range(0, 15));
      lane_in[2] = 4'($urandom_range(0, 15));
      cycle();
      if (n >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_select !== (((n - 1) % 2) ? 2'b10 : 2'b00) || out_data !== od_m) begin
          failures++;
          $display("FAIL alternate n=%0d got v=%b s=%b d=%h exp v=1 s=%b d=%h",
                   n, out_valid, out_select, out_data, (((n - 1) % 2) ? 2'b10 : 2'b00), od_m);
        end
      end
    end
    in_valid = '0;
  endtask

  task automatic test_hold();
    apply_reset();
    in_valid   = 4'b1000;
    lane_in[3] = 4'h7;
    out_ready  = 1'b0;
    cycle();
    in_valid = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h7 || out_select !== 2'b11) begin
      failures++;
      $display("FAIL hold_load got v=%b d=%h s=%b exp v=1 d=7 s=11", out_valid, out_data, out_select);
    end
    for (int n = 0; n < 5; n++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h7 || out_select !== 2'b11 || in_ready[3] !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable n=%0d got v=%b d=%h s=%b rdy3=%b exp v=1 d=7 s=11 rdy3=1",
                 n, out_valid, out_data, out_select, in_ready[3]);
      end
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", out_valid); end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lane_in[0] = 4'h1;
    lane_in[1] = 4'h2;
    lane_in[2] = 4'h3;
    in_valid   = 4'b0111;
    out_ready  = 1'b0;
    cycle();
    cycle();
    lane_in[0] = 4'h9;
    cycle();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_setup got v=%b rdy=%b exp v=1 rdy=1000", out_valid, in_ready);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b1111 || out_data !== 4'h0 || out_select !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async got v=%b rdy=%b d=%h s=%b exp v=0 rdy=1111 d=0 s=00",
               out_valid, in_ready, out_data, out_select);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    in_valid   = 4'b1000;
    lane_in[3] = 4'h5;
    out_ready  = 1'b1;
    cycle();
    in_valid = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_select !== 2'b11 || out_data !== 4'h5) begin
      failures++;
      $display("FAIL midrst_resume got v=%b s=%b d=%h exp v=1 s=11 d=5", out_valid, out_select, out_data);
    end
  endtask

  task automatic test_stress();
    logic [3:0] exp_rdy;
    apply_reset();
    for (int n = 0; n < 10000; n++) begin
      in_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) lane_in[i] = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < 4; i++) exp_rdy[i] = (lane_q[i].size() == 0);
      checks++;
      if (out_valid !== ov_m || in_ready !== exp_rdy || out_data !== od_m || out_select !== os_m) begin
        failures++;
        $display("FAIL stress n=%0d got v=%b rdy=%b d=%h s=%b exp v=%b rdy=%b d=%h s=%b",
                 n, out_valid, in_ready, out_data, out_select, ov_m, exp_rdy, od_m, os_m);
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b1111 ||
        (lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size()) != 0) begin
      failures++;
      $display("FAIL stress_drain got v=%b rdy=%b exp v=0 rdy=1111 with empty scoreboard", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_1_rr.md
MUX4_1_RR -- requirements
Module: mux4_1_rr

Interface
REQ-001 Parameter DATA_W, default 4: width of every data lane.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  4  bit i set: lane i+1 presents a beat.
REQ-005 in_ready  output  4  bit i set: lane i+1 buffer can accept.
REQ-006 in_data_1  input  DATA_W  lane 1 data, select code 2'b00.
REQ-007 in_data_2  input  DATA_W  lane 2 data, select code 2'b01.
REQ-008 in_data_3  input  DATA_W  lane 3 data, select code 2'b10.
REQ-009 in_data_4  input  DATA_W  lane 4 data, select code 2'b11.
REQ-010 out_valid  output  1  output register holds a beat.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_data  output  DATA_W  merged data.
REQ-013 out_select  output  2  source lane code of out_data; drives a downstream 1:4 demux directly.

Function
REQ-014 Each lane SHALL have a 1-entry buffer (data + full flag); in_ready[i] = ~full[i], purely registered.
REQ-015 Accept on lane i: in_valid[i] & in_ready[i] at a rising edge; data captured, full[i] set.
REQ-016 Output register loads when empty or draining (out_valid & out_ready) and at least one lane buffer is full.
REQ-017 Grant SHALL be round-robin: search starts at last_grant+1 modulo 4; first full lane wins.
REQ-018 On grant: out_data <= buffer, out_select <= lane code, out_valid <= 1, full[lane] <= 0, last_grant <= lane, all at one edge.
REQ-019 Output drains with no new grant: out_valid <= 0; out_data and out_select hold their last values.
REQ-020 out_valid high and out_ready low: out_data, out_select and out_valid SHALL remain stable.
REQ-021 Latency: a beat accepted at edge N appears with out_valid at edge N+1 at the earliest.
REQ-022 Throughput: with out_ready held high, one beat per cycle aggregate when at least 2 lanes are loaded; a single lane sustains one beat per 2 cycles.
REQ-023 A lane's grant and new acceptance SHALL NOT occur at the same edge, because in_ready is low while the buffer is full.
REQ-024 last_grant SHALL be unchanged on cycles with no grant.
REQ-025 No beat SHALL be dropped or duplicated; per-lane order is preserved.

Reset
REQ-026 On reset assertion, asynchronously: full = 4'b0000, in_ready = 4'b1111 (combinational from full), out_valid = 0, out_data = 0, out_select = 2'b00, last_grant = 2'b11 so lane 1 has first priority.
REQ-027 Reset mid-operation discards all buffered and output beats with no partial output.
REQ-028 Operation resumes at the first rising clk edge after deassertion.

Structure
REQ-029 A shared package SHALL hold DATA_W default, NUM_CH = 4 and the lane select codes 2'b00..2'b11, shared with the demux.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter4: inputs req[3:0] and last[1:0]; outputs gnt_valid and gnt[1:0]; purely combinational.
REQ-031 Expected size: 120-250 lines of RTL including the sub-module.

Verification
REQ-032 Reset then lane 2 sends 4'hA, out_ready = 1 -> next cycle out_valid = 1, out_data = 4'hA, out_select = 2'b01; following cycle out_valid = 0.
REQ-033 All four lanes load 4'h1, 4'h2, 4'h3, 4'h4 in one cycle, out_ready = 1 -> outputs 1, 2, 3, 4 on consecutive cycles with select codes 00, 01, 10, 11.
REQ-034 Lanes 1 and 3 continuously valid, out_ready = 1 -> grants strictly alternate 00, 10, 00, 10; neither lane starves.
REQ-035 out_ready = 0 for 5 cycles with out_valid = 1 (4'h7, lane 4) -> out_data, out_select and out_valid stable; in_ready[3] stays 1 after the hold; on release the beat is accepted exactly once.
REQ-036 Reset asserted while lanes 1-3 are full and out_valid = 1 -> immediately out_valid = 0 and in_ready = 4'b1111; after release a fresh beat on lane 4 is granted first-come with select 2'b11.
REQ-037 Random valid/ready stress for 10k cycles: scoreboard per lane confirms no loss, duplication or reordering.
